// File: rtl/jvm_decode_sequencer.sv
// JVM instruction decode sequencer: fetches an opcode, walks its operand
// bytes in two-cycle half steps, then iterates the micro-op ROM chain.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   waiting, flush    stall (freeze) and abort current instruction
//   iram_data         instruction byte
//   parameter_number  operand byte count of the opcode on iram_data
//   next_adr          next micro-op address from ROM (0 = end of chain)
//   state             FETCH=0, DECODE=1, PARAMS=2, ITER=3
//   com_adr           current micro-op address
//   jvm_opcode        latched opcode
//   q_select          1 = operand queue fetch mode, 0 = iterate mode
//   param_even        half-step phase of the current operand byte
//   push_wide         high for the final PARAMS cycle
//   is_wide           wide prefix pending or active
//   param_idx         operand byte index
//   fetch_req         combinational, high in FETCH
//   instr_done        one-cycle pulse at instruction end
module jvm_decode_sequencer #(
    parameter int          ADR_W   = 8,
    parameter int          PARAM_W = 3,
    parameter logic [7:0]  WIDE_OP = 8'hC4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waiting,
    input  logic               flush,
    input  logic [7:0]         iram_data,
    input  logic [PARAM_W-1:0] parameter_number,
    input  logic [ADR_W-1:0]   next_adr,
    output logic [1:0]         state,
    output logic [ADR_W-1:0]   com_adr,
    output logic [7:0]         jvm_opcode,
    output logic               q_select,
    output logic               param_even,
    output logic               push_wide,
    output logic               is_wide,
    output logic [PARAM_W:0]   param_idx,
    output logic               fetch_req,
    output logic               instr_done
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        PARAMS = 2'd2,
        ITER   = 2'd3
    } state_t;

    state_t           state_q;
    logic [PARAM_W:0] target;
    logic [PARAM_W:0] target_next;

    // A wide prefix doubles the operand byte count; the extra bit of
    // width keeps the doubled count from overflowing.
    assign target_next = is_wide ? {parameter_number, 1'b0}
                                 : {1'b0, parameter_number};

    assign state     = state_q;
    assign fetch_req = (state_q == FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            com_adr    <= '0;
            jvm_opcode <= '0;
            q_select   <= 1'b0;
            param_even <= 1'b0;
            push_wide  <= 1'b0;
            is_wide    <= 1'b0;
            param_idx  <= '0;
            instr_done <= 1'b0;
            target     <= '0;
        end else if (flush) begin
            // Redirect: drop the instruction but keep com_adr/jvm_opcode.
            state_q    <= FETCH;
            q_select   <= 1'b0;
            param_even <= 1'b0;
            push_wide  <= 1'b0;
            is_wide    <= 1'b0;
            param_idx  <= '0;
            instr_done <= 1'b0;
        end else begin
            // The done pulse never outlives its edge, even across a stall.
            instr_done <= 1'b0;
            if (!waiting) begin
                unique case (state_q)
                    FETCH: begin
                        state_q <= DECODE;
                    end
                    DECODE: begin
                        jvm_opcode <= iram_data;
                        param_idx  <= '0;
                        param_even <= 1'b0;
                        if (iram_data == WIDE_OP) begin
                            is_wide <= 1'b1;
                            state_q <= FETCH;
                        end else if (target_next != '0) begin
                            target   <= target_next;
                            q_select <= 1'b1;
                            state_q  <= PARAMS;
                        end else begin
                            target   <= '0;
                            com_adr  <= ADR_W'(iram_data);
                            q_select <= 1'b0;
                            state_q  <= ITER;
                        end
                    end
                    PARAMS: begin
                        if (param_idx < target) begin
                            param_even <= ~param_even;
                            if (param_even)
                                param_idx <= param_idx + 1'b1;
                        end else if (!push_wide) begin
                            push_wide <= 1'b1;
                        end else begin
                            com_adr    <= ADR_W'(jvm_opcode);
                            q_select   <= 1'b0;
                            param_even <= 1'b0;
                            push_wide  <= 1'b0;
                            state_q    <= ITER;
                        end
                    end
                    ITER: begin
                        is_wide <= 1'b0;
                        if (next_adr != '0) begin
                            com_adr <= next_adr;
                        end else begin
                            instr_done <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jvm_decode_sequencer.sv
// Directed self-checking bench for jvm_decode_sequencer.
// Micro-op ROM modelled as a small lookup on com_adr.
module tb_jvm_decode_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       waiting;
    logic       flush;
    logic [7:0] iram_data;
    logic [2:0] parameter_number;
    logic [7:0] next_adr;
    logic [1:0] state;
    logic [7:0] com_adr;
    logic [7:0] jvm_opcode;
    logic       q_select;
    logic       param_even;
    logic       push_wide;
    logic       is_wide;
    logic [3:0] param_idx;
    logic       fetch_req;
    logic       instr_done;

    int tests = 0;
    int fails = 0;
    int n;

    jvm_decode_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .waiting          (waiting),
        .flush            (flush),
        .iram_data        (iram_data),
        .parameter_number (parameter_number),
        .next_adr         (next_adr),
        .state            (state),
        .com_adr          (com_adr),
        .jvm_opcode       (jvm_opcode),
        .q_select         (q_select),
        .param_even       (param_even),
        .push_wide        (push_wide),
        .is_wide          (is_wide),
        .param_idx        (param_idx),
        .fetch_req        (fetch_req),
        .instr_done       (instr_done)
    );

    always #5 clk = ~clk;

    // ROM: 0x60 chains to 0x61, everything else ends the chain.
    always_comb next_adr = (com_adr == 8'h60) ? 8'h61 : 8'h00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; waiting = 1'b0; flush = 1'b0;
        iram_data = 8'h00; parameter_number = 3'd0;
        step(); step();
        check("rst_state", state, 0);
        check("rst_com", com_adr, 0);
        check("rst_op", jvm_opcode, 0);
        check("rst_flags", {q_select, param_even, push_wide, is_wide}, 0);
        check("rst_idx", param_idx, 0);
        check("rst_done", instr_done, 0);
        check("rst_freq", fetch_req, 1);
        reset = 1'b0;

        // Opcode 0x60, no operands, two-step micro-op chain
        iram_data = 8'h60; parameter_number = 3'd0;
        step(); check("i60_dec", state, 1);
        check("i60_freq", fetch_req, 0);
        step(); check("i60_it1", state, 3);
        check("i60_com1", com_adr, 8'h60);
        check("i60_q", q_select, 0);
        step(); check("i60_com2", com_adr, 8'h61);
        check("i60_st2", state, 3);
        check("i60_done0", instr_done, 0);
        step(); check("i60_fetch", state, 0);
        check("i60_done", instr_done, 1);
        step(); check("i60_dec2", state, 1);
        check("i60_pulse", instr_done, 0);

        // Opcode 0x10 with one operand byte
        iram_data = 8'h10; parameter_number = 3'd1;
        step(); check("i10_p1", {state, param_even, push_wide}, 4'b1000);
        check("i10_op", jvm_opcode, 8'h10);
        check("i10_q", q_select, 1);
        step(); check("i10_p2", {state, param_even, push_wide}, 4'b1010);
        check("i10_idx2", param_idx, 0);
        step(); check("i10_p3", {state, param_even, push_wide}, 4'b1000);
        check("i10_idx3", param_idx, 1);
        step(); check("i10_p4", {state, param_even, push_wide}, 4'b1001);
        step(); check("i10_it", state, 3);
        check("i10_com", com_adr, 8'h10);
        check("i10_qs", q_select, 0);
        check("i10_pw", push_wide, 0);
        step(); check("i10_done", {state, instr_done}, 3'b001);

        // Wide prefix then 0x15 with one operand byte: T = 2
        iram_data = 8'hC4; parameter_number = 3'd1;
        step(); step();
        check("wide_fetch", state, 0);
        check("wide_set", is_wide, 1);
        step(); check("wide_dec", state, 1);
        iram_data = 8'h15;
        step(); check("wide_par", state, 2);
        n = 0;
        while (state == 2'd2 && n < 20) begin
            check("wide_iw", is_wide, 1);
            n++;
            step();
        end
        check("wide_cnt", n, 6);
        check("wide_it", state, 3);
        check("wide_com", com_adr, 8'h15);
        check("wide_iw_it", is_wide, 1);
        step(); check("wide_clr", is_wide, 0);
        check("wide_done", instr_done, 1);

        // Stall mid-PARAMS for three cycles
        iram_data = 8'h10; parameter_number = 3'd1;
        step(); step(); step();
        check("st_pre", {state, param_even, param_idx}, 7'b1010000);
        waiting = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_hold", {state, param_even, param_idx, push_wide,
                              q_select}, 9'b101000001);
            check("st_com", com_adr, 8'h15);
        end
        waiting = 1'b0;
        step(); check("st_r1", {state, param_even, param_idx}, 7'b1000001);
        step(); check("st_r2", push_wide, 1);
        step(); check("st_r3", {state, com_adr}, {2'd3, 8'h10});
        step(); check("st_r4", {state, instr_done}, 3'b001);

        // Flush while stalled: back to FETCH, com_adr held
        iram_data = 8'h20; parameter_number = 3'd1;
        step(); step(); step();
        waiting = 1'b1; flush = 1'b1;
        step();
        waiting = 1'b0; flush = 1'b0;
        check("fl_state", state, 0);
        check("fl_com", com_adr, 8'h10);
        check("fl_op", jvm_opcode, 8'h20);
        check("fl_flags", {q_select, param_even, push_wide, is_wide}, 0);
        check("fl_idx", param_idx, 0);

        // Reset during ITER at com_adr 0x61, then a clean instruction
        iram_data = 8'h60; parameter_number = 3'd0;
        step(); step(); step();
        check("rs_pre", {state, com_adr}, {2'd3, 8'h61});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rs_state", state, 0);
        check("rs_com", com_adr, 0);
        check("rs_op", jvm_opcode, 0);
        check("rs_done", instr_done, 0);
        step(); step();
        check("rs_it", {state, com_adr}, {2'd3, 8'h60});
        step(); step();
        check("rs_end", {state, instr_done}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jvm_decode_sequencer.md
JVM_DECODE_SEQUENCER -- requirements
Module: jvm_decode_sequencer

Interface
REQ-001 SHALL have parameter ADR_W, default 8, width of the micro-op ROM address.
REQ-002 SHALL have parameter PARAM_W, default 3, width of the parameter-byte count.
REQ-003 SHALL have parameter WIDE_OP, default 8'hC4, the opcode of the JVM wide prefix.
REQ-004 SHALL have one clock and a synchronous active-high reset: ports clk and reset.
REQ-005 Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- waiting  in  1  stall; freezes the sequencer.
- flush  in  1  aborts the current instruction (branch redirect).
- iram_data  in  8  instruction byte.
- parameter_number  in  PARAM_W  operand bytes of the opcode on iram_data.
- next_adr  in  ADR_W  next micro-op address from external ROM, indexed by com_adr; 0 means end.
- state  out  2  FETCH=0, DECODE=1, PARAMS=2, ITER=3.
- com_adr  out  ADR_W  current micro-op address.
- jvm_opcode  out  8  latched opcode.
- q_select  out  1  1 = operand queue in fetch mode, 0 = iterate mode.
- param_even  out  1  half-step phase of the operand byte.
- push_wide  out  1  high for the final PARAMS cycle.
- is_wide  out  1  wide prefix pending or active.
- param_idx  out  PARAM_W+1  operand byte index.
- fetch_req  out  1  combinational: state==FETCH.
- instr_done  out  1  registered one-cycle pulse at instruction end.

Function
REQ-006 "Advance" SHALL mean a rising clk edge with reset=0, flush=0 and waiting=0; no register SHALL change on a non-advance edge except as set by REQ-015/016.
REQ-007 FETCH SHALL go to DECODE on advance.
REQ-008 DECODE SHALL latch jvm_opcode<=iram_data and set param_idx<=0 and param_even<=0.
REQ-009 DECODE with iram_data==WIDE_OP SHALL set is_wide<=1 and go to FETCH; consecutive prefixes SHALL leave is_wide=1.
REQ-010 DECODE otherwise SHALL compute target T = parameter_number << is_wide, using PARAM_W+1 bits with no overflow.
- T!=0: go to PARAMS and set q_select<=1.
- T==0: go to ITER, set com_adr<=zero-extended iram_data and q_select<=0.
REQ-011 PARAMS with param_idx<T SHALL toggle param_even on each advance.
- param_idx SHALL increment on the advance where param_even==1.
- Each operand byte therefore takes exactly 2 cycles.
REQ-012 PARAMS with param_idx==T SHALL assert push_wide<=1 for one cycle.
- The following advance SHALL go to ITER and set com_adr<=jvm_opcode, q_select<=0, param_even<=0 and push_wide<=0.
- PARAMS residency SHALL be 2T+2 advancing cycles.
REQ-013 ITER SHALL clear is_wide<=0 on every advance.
- next_adr!=0: com_adr<=next_adr, stay in ITER.
- next_adr==0: go to FETCH and pulse instr_done<=1.
REQ-014 instr_done SHALL be 0 on every edge other than the one described in REQ-013.
REQ-015 flush SHALL take effect regardless of waiting.
- It SHALL set state<=FETCH and clear is_wide, q_select, param_even, push_wide, param_idx and instr_done.
- com_adr and jvm_opcode SHALL be held.
REQ-016 Priority SHALL be reset > flush > waiting > normal operation.

Reset
REQ-017 reset SHALL set state=FETCH and set com_adr, jvm_opcode, q_select, param_even, push_wide, is_wide, param_idx and instr_done to 0 on the next edge, including mid-PARAMS or mid-ITER.

Verification
REQ-018 Opcode 8'h60 with parameter_number=0 and next_adr sequence 0x61 then 0: FETCH, DECODE, ITER (com_adr=0x60), ITER (0x61), then instr_done=1 and state=FETCH.
REQ-019 Opcode 8'h10 with parameter_number=1: PARAMS for 4 cycles with param_even 0,1,0 then push_wide=1, then ITER with com_adr=0x10 and q_select=0.
REQ-020 Byte C4 then 8'h15 with parameter_number=1: T=2 and 6 PARAMS cycles; is_wide=1 until the first ITER advance, then 0.
REQ-021 waiting=1 for 3 cycles mid-PARAMS: all outputs frozen, then the sequence resumes without loss; flush asserted during waiting forces FETCH next edge with com_adr unchanged.
REQ-022 reset pulse during ITER with com_adr=0x61: all outputs at 0 and state=FETCH next cycle; the next instruction decodes normally.
